// File: rtl/util_fir_dec.sv
// util_fir_dec
// Boxcar decimator for paired 16-bit signed ADC samples, with an AXI-Stream
// master output behind a small first-word-fall-through FIFO.
//
// Each channel sums DEC_RATE consecutive valid samples, shifts the sum
// right arithmetically by log2(DEC_RATE), and pushes the packed pair
// {ch1, ch0} into the FIFO. In bypass mode every valid sample pair is
// pushed unchanged.
//
// Build option:
//   UTIL_FIR_DEC_ROUND_EN  defined   -> round half up (add 2^(K-1) before shift)
//                          undefined -> truncate (floor)
//
// Ports:
//   aclk                 clock
//   areset               asynchronous active-high reset
//   s_axis_data_tvalid   input sample strobe (never stalled)
//   channel_0/channel_1  signed input samples (I/Q)
//   decimate             1 = decimate by DEC_RATE, 0 = bypass
//   overflow_clr         synchronous clear of the sticky overflow flag
//   m_axis_data_tvalid   output word valid
//   m_axis_data_tready   downstream ready
//   m_axis_data_tdata    {ch1, ch0}
//   overflow             sticky: a result was dropped on a full FIFO

module util_fir_dec #(
  parameter int DEC_RATE   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        s_axis_data_tvalid,
  input  logic [15:0] channel_0,
  input  logic [15:0] channel_1,
  input  logic        decimate,
  input  logic        overflow_clr,
  output logic        m_axis_data_tvalid,
  input  logic        m_axis_data_tready,
  output logic [31:0] m_axis_data_tdata,
  output logic        overflow
);

  localparam int K     = $clog2(DEC_RATE);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ACC_W = 16 + K;

`ifdef UTIL_FIR_DEC_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(2 ** (K - 1));
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  localparam logic [K-1:0]  LAST_PHASE = K'(DEC_RATE - 1);
  localparam logic [AW:0]   DEPTH_CNT  = (AW + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------
  // Accumulate-and-dump datapath
  // ---------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
  logic        [K-1:0]     phase_q, phase_d;
  logic                    dec_prev_q, dec_prev_d;

  logic signed [ACC_W-1:0] acc0_base, acc1_base;
  logic        [K-1:0]     phase_base;
  logic signed [ACC_W-1:0] add0, add1, sum0, sum1;
  logic [15:0]             res0, res1;

  logic                    push;
  logic [31:0]             push_data;

  always_comb begin
    dec_prev_d = decimate;

    // A mode change discards any partial block; the sample on the changing
    // cycle starts fresh in the new mode.
    acc0_base  = acc0_q;
    acc1_base  = acc1_q;
    phase_base = phase_q;
    if (decimate != dec_prev_q) begin
      acc0_base  = '0;
      acc1_base  = '0;
      phase_base = '0;
    end

    add0 = acc0_base + {{K{channel_0[15]}}, channel_0};
    add1 = acc1_base + {{K{channel_1[15]}}, channel_1};
    sum0 = add0 + RND;
    sum1 = add1 + RND;
    // The block average always fits 16 bits, so the upper bits are just
    // sign copies and can be dropped.
    res0 = 16'(sum0 >>> K);
    res1 = 16'(sum1 >>> K);

    push      = 1'b0;
    push_data = '0;
    acc0_d    = acc0_base;
    acc1_d    = acc1_base;
    phase_d   = phase_base;

    if (s_axis_data_tvalid) begin
      if (decimate) begin
        if (phase_base == LAST_PHASE) begin
          push      = 1'b1;
          push_data = {res1, res0};
          acc0_d    = '0;
          acc1_d    = '0;
          phase_d   = '0;
        end else begin
          acc0_d  = add0;
          acc1_d  = add1;
          phase_d = phase_base + 1'b1;
        end
      end else begin
        push      = 1'b1;
        push_data = {channel_1, channel_0};
        acc0_d    = '0;
        acc1_d    = '0;
        phase_d   = '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic full, empty, pop, push_ok, drop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == DEPTH_CNT);
    pop     = !empty && m_axis_data_tready;
    // A full FIFO still accepts a word if the head leaves on the same edge.
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Set wins over a same-cycle clear.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc0_q     <= '0;
      acc1_q     <= '0;
      phase_q    <= '0;
      dec_prev_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      acc0_q     <= acc0_d;
      acc1_q     <= acc1_d;
      phase_q    <= phase_d;
      dec_prev_q <= dec_prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign m_axis_data_tvalid = !empty;
  assign m_axis_data_tdata  = empty ? 32'h0 : mem_q[rd_ptr_q];
  assign overflow           = overflow_q;

endmodule

// File: tb/tb_util_fir_dec.sv
module tb_util_fir_dec;

  localparam int DEC_RATE   = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int K          = 3;
`ifdef UTIL_FIR_DEC_ROUND_EN
  localparam int RND = 1 << (K - 1);
  localparam bit ROUND = 1'b1;
`else
  localparam int RND = 0;
  localparam bit ROUND = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic        s_axis_data_tvalid;
  logic [15:0] channel_0, channel_1;
  logic        decimate;
  logic        overflow_clr;
  logic        m_axis_data_tvalid;
  logic        m_axis_data_tready;
  logic [31:0] m_axis_data_tdata;
  logic        overflow;

  always #5 aclk = ~aclk;

  util_fir_dec #(.DEC_RATE(DEC_RATE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .aclk               (aclk),
    .areset             (areset),
    .s_axis_data_tvalid (s_axis_data_tvalid),
    .channel_0          (channel_0),
    .channel_1          (channel_1),
    .decimate           (decimate),
    .overflow_clr       (overflow_clr),
    .m_axis_data_tvalid (m_axis_data_tvalid),
    .m_axis_data_tready (m_axis_data_tready),
    .m_axis_data_tdata  (m_axis_data_tdata),
    .overflow           (overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: a block of pending samples per channel, a word queue
  // for the FIFO and a sticky flag.
  logic [31:0] m_fifo[$];
  int          blk0[$];
  int          blk1[$];
  bit          m_ovf;
  bit          m_prev_dec;
  logic [31:0] got[$];

  function automatic logic [15:0] block_avg(input int s);
    return 16'((s + RND) >>> K);
  endfunction

  task automatic model_clear();
    m_fifo.delete();
    blk0.delete();
    blk1.delete();
    m_ovf = 1'b0;
  endtask

  task automatic step(input bit v, input logic [15:0] c0, input logic [15:0] c1,
                      input bit dec, input bit rdy, input bit clr);
    bit          has_push, pop, full, drop;
    logic [31:0] word;
    int          s0, s1;
    @(negedge aclk);
    chk("tvalid", {31'b0, m_axis_data_tvalid}, {31'b0, (m_fifo.size() != 0)});
    if (m_fifo.size() != 0) chk("tdata", m_axis_data_tdata, m_fifo[0]);
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});

    s_axis_data_tvalid = v;
    channel_0          = c0;
    channel_1          = c1;
    decimate           = dec;
    m_axis_data_tready = rdy;
    overflow_clr       = clr;
    if (m_axis_data_tvalid && rdy) got.push_back(m_axis_data_tdata);

    pop      = (m_fifo.size() != 0) && rdy;
    has_push = 1'b0;
    word     = '0;
    if (dec != m_prev_dec) begin
      blk0.delete();
      blk1.delete();
    end
    m_prev_dec = dec;
    if (v) begin
      if (!dec) begin
        has_push = 1'b1;
        word     = {c1, c0};
      end else begin
        blk0.push_back(int'($signed(c0)));
        blk1.push_back(int'($signed(c1)));
        if (blk0.size() == DEC_RATE) begin
          s0 = 0;
          s1 = 0;
          foreach (blk0[i]) s0 += blk0[i];
          foreach (blk1[i]) s1 += blk1[i];
          has_push = 1'b1;
          word     = {block_avg(s1), block_avg(s0)};
          blk0.delete();
          blk1.delete();
        end
      end
    end
    full = (m_fifo.size() == FIFO_DEPTH);
    drop = has_push && full && !pop;
    if (pop) void'(m_fifo.pop_front());
    if (has_push && !drop) m_fifo.push_back(word);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic idle(input int n, input bit rdy, input bit dec);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, dec, rdy, 1'b0);
  endtask

  task automatic reset_async();
    @(negedge aclk);
    s_axis_data_tvalid = 1'b0;
    overflow_clr       = 1'b0;
    #2 areset = 1'b1;
    #1;
    chk("rst_tvalid", {31'b0, m_axis_data_tvalid}, 32'h0);
    chk("rst_ovf", {31'b0, overflow}, 32'h0);
    chk("rst_tdata", m_axis_data_tdata, 32'h0);
    model_clear();
    m_prev_dec = decimate;
    @(negedge aclk);
    areset = 1'b0;
  endtask

  initial begin
    bit          dec_r;
    logic [15:0] r0, r1;
    logic [15:0] ext[4];

    areset             = 1'b1;
    s_axis_data_tvalid = 1'b0;
    channel_0          = '0;
    channel_1          = '0;
    decimate           = 1'b0;
    overflow_clr       = 1'b0;
    m_axis_data_tready = 1'b0;
    model_clear();
    m_prev_dec = 1'b0;
    #12;
    chk("init_tvalid", {31'b0, m_axis_data_tvalid}, 32'h0);
    chk("init_tdata", m_axis_data_tdata, 32'h0);
    chk("init_ovf", {31'b0, overflow}, 32'h0);
    @(negedge aclk);
    areset = 1'b0;

    // Bypass pass-through
    got.delete();
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 16'h0, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b0);
    chk("byp_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk("byp_word", (got.size() > i) ? got[i] : 32'hx, 32'(i + 1));
    chk("byp_ovf", {31'b0, overflow}, 32'h0);

    // Decimation, constant input
    got.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 16'h1000, 16'hF000, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b1);
    chk("dec_count", got.size(), 2);
    for (int i = 0; i < 2; i++) chk("dec_word", (got.size() > i) ? got[i] : 32'hx, 32'hF0001000);

    got.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b1);
    chk("ext_count", got.size(), 2);
    chk("ext_max", (got.size() > 0) ? got[0] : 32'hx, 32'h7FFF7FFF);
    chk("ext_min", (got.size() > 1) ? got[1] : 32'hx, 32'h80008000);

    // Rounding vs truncation
    got.delete();
    for (int i = 0; i < 7; i++) step(1'b1, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'h0004, 16'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'hFFFC, 16'h0, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b1);
    chk("rnd_count", got.size(), 2);
    chk("rnd_pos", (got.size() > 0) ? got[0] : 32'hx, ROUND ? 32'h00000001 : 32'h00000000);
    chk("rnd_neg", (got.size() > 1) ? got[1] : 32'hx, ROUND ? 32'h00000000 : 32'h0000FFFF);

    // Backpressure and overflow
    got.delete();
    for (int i = 1; i <= 6; i++) step(1'b1, 16'(i), 16'h0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    chk("bp_ovf_set", {31'b0, overflow}, 32'h1);
    chk("bp_held", got.size(), 0);
    idle(6, 1'b1, 1'b0);
    chk("bp_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk("bp_word", (got.size() > i) ? got[i] : 32'hx, 32'(i + 1));
    chk("bp_ovf_sticky", {31'b0, overflow}, 32'h1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1, 1'b0);
    chk("bp_ovf_clr", {31'b0, overflow}, 32'h0);

    // Mode change discards partial block
    got.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0100, 16'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'h0007, 16'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h0008, 16'h0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b0);
    chk("mc_count", got.size(), 2);
    chk("mc_w0", (got.size() > 0) ? got[0] : 32'hx, 32'h7);
    chk("mc_w1", (got.size() > 1) ? got[1] : 32'hx, 32'h8);
    got.delete();
    for (int i = 0; i < 7; i++) step(1'b1, 16'h0008, 16'h0008, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b1);
    chk("mc_partial", got.size(), 0);
    step(1'b1, 16'h0008, 16'h0008, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b1);
    chk("mc_full_count", got.size(), 1);
    chk("mc_full_word", (got.size() > 0) ? got[0] : 32'hx, 32'h00080008);

    // Reset mid-block with buffered words and overflow set
    got.delete();
    for (int i = 1; i <= 5; i++) step(1'b1, 16'(i), 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0010, 16'h0010, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_tvalid", {31'b0, m_axis_data_tvalid}, 32'h1);
    chk("pre_rst_ovf", {31'b0, overflow}, 32'h1);
    reset_async();
    got.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0010, 16'h0010, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b1);
    chk("rst_count", got.size(), 1);
    chk("rst_word", (got.size() > 0) ? got[0] : 32'hx, 32'h00100010);

    // Randomized traffic against the model
    ext[0] = 16'h7FFF;
    ext[1] = 16'h8000;
    ext[2] = 16'h0000;
    ext[3] = 16'hFFFF;
    dec_r  = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 4) dec_r = ~dec_r;
      r0 = ($urandom_range(0, 4) == 0) ? ext[$urandom_range(0, 3)] : 16'($urandom);
      r1 = ($urandom_range(0, 4) == 0) ? ext[$urandom_range(0, 3)] : 16'($urandom);
      step($urandom_range(0, 99) < 75, r0, r1, dec_r,
           $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
    end
    idle(FIFO_DEPTH + 2, 1'b1, dec_r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
